clock12_sequencer: RTL and testbench

//   Sequences a cascade of BCD time counters into a 12-hour clock (hh:mm:ss + AM/PM).

---
 rtl/clock12_sequencer.sv | 146 ++++++++++++++
 tb/tb_clock12_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock12_sequencer.sv
// clock12_sequencer: sequences BCD hh:mm:ss counters into a 12-hour clock with AM/PM.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   enable, run           - tick strobe, run/hold level
//   set_valid/set_ready   - time-set handshake; set_hh/mm/ss/pm are the load operands
//   hh, mm, ss, pm        - current time (BCD) and PM flag
//   set_err               - one-cycle pulse on a rejected set request
//   sec_tick              - one-cycle pulse when ss advances
module clock12_sequencer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       set_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       set_err,
  output logic       sec_tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc;
  logic [7:0]    ld_hh, ld_mm, ld_ss;
  logic          ld_pm;

  logic          handshake_c, set_ok_c, tick_c, advance_c;
  logic [7:0]    hh_inc_c, mm_inc_c, ss_inc_c;
  logic          pm_inc_c;

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Increment a valid BCD byte; low-digit 9 carries into the high digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] hi, lo;
    hi = v[7:4];
    lo = v[3:0];
    if (lo == 4'd9) return {hi + 4'd1, 4'd0};
    else            return {hi, lo + 4'd1};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= STOP;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (handshake_c && set_ok_c) state_nxt = LOAD;
               else if (run)                state_nxt = RUN;
      RUN:     if (handshake_c && set_ok_c) state_nxt = LOAD;
               else if (!run)               state_nxt = STOP;
      LOAD:    state_nxt = run ? RUN : STOP;
      default: state_nxt = STOP;
    endcase
  end

  // Handshake qualification, tick gating and the carry cascade
  always_comb begin
    handshake_c = set_valid && set_ready;
    set_ok_c    = bcd_ok(set_hh) && bcd_ok(set_mm) && bcd_ok(set_ss) &&
                  (set_hh >= 8'h01) && (set_hh <= 8'h12) &&
                  (set_mm <= 8'h59) && (set_ss <= 8'h59);
    // A tick coinciding with any handshake is dropped; LOAD never counts ticks.
    tick_c      = enable && (state == RUN) && !handshake_c;
    advance_c   = tick_c && (presc == PW'(PRESCALE - 1));

    ss_inc_c = (ss == 8'h59) ? 8'h00 : bcd_inc(ss);
    mm_inc_c = mm;
    hh_inc_c = hh;
    pm_inc_c = pm;
    if (ss == 8'h59) begin
      mm_inc_c = (mm == 8'h59) ? 8'h00 : bcd_inc(mm);
      if (mm == 8'h59) begin
        if (hh == 8'h12) hh_inc_c = 8'h01;
        else             hh_inc_c = bcd_inc(hh);
        if (hh == 8'h11) pm_inc_c = ~pm;
      end
    end
  end

  // Time registers, prescaler, operand capture and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      hh        <= 8'h12;
      mm        <= 8'h00;
      ss        <= 8'h00;
      pm        <= 1'b0;
      presc     <= '0;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      set_ready <= 1'b1;
      ld_hh     <= 8'h12;
      ld_mm     <= 8'h00;
      ld_ss     <= 8'h00;
      ld_pm     <= 1'b0;
    end else begin
      set_err   <= handshake_c && !set_ok_c;
      sec_tick  <= advance_c;
      set_ready <= (state_nxt != LOAD);
      if (handshake_c && set_ok_c) begin
        ld_hh <= set_hh;
        ld_mm <= set_mm;
        ld_ss <= set_ss;
        ld_pm <= set_pm;
      end
      if (state == LOAD) begin
        hh    <= ld_hh;
        mm    <= ld_mm;
        ss    <= ld_ss;
        pm    <= ld_pm;
        presc <= '0;
      end else if (tick_c) begin
        presc <= advance_c ? '0 : presc + PW'(1);
        if (advance_c) begin
          hh <= hh_inc_c;
          mm <= mm_inc_c;
          ss <= ss_inc_c;
          pm <= pm_inc_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock12_sequencer.sv
module tb_clock12_sequencer;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
  } tm_t;

  logic       clk = 1'b0;
  logic       reset, enable, run, set_valid, set_pm;
  logic [7:0] set_hh, set_mm, set_ss;
  logic       set_ready, pm, set_err, sec_tick;
  logic [7:0] hh, mm, ss;

  tm_t exp_q[$];
  tm_t mdl;
  tm_t got;
  tm_t exp_t;
  int  checks   = 0;
  int  failures = 0;

  localparam tm_t MIDNIGHT = '{hh: 8'h12, mm: 8'h00, ss: 8'h00, pm: 1'b0};

  clock12_sequencer #(.PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .run(run),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .set_err(set_err), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  function automatic tm_t now_t();
    return '{hh: hh, mm: mm, ss: ss, pm: pm};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Reference model: one second forward in integer arithmetic.
  function automatic tm_t model_inc(input tm_t t);
    int h, m, s;
    logic p;
    h = from_bcd(t.hh); m = from_bcd(t.mm); s = from_bcd(t.ss); p = t.pm;
    s = s + 1;
    if (s == 60) begin
      s = 0; m = m + 1;
      if (m == 60) begin
        m = 0;
        if (h == 11)      begin h = 12; p = ~p; end
        else if (h == 12) h = 1;
        else              h = h + 1;
      end
    end
    return '{hh: to_bcd(h), mm: to_bcd(m), ss: to_bcd(s), pm: p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input tm_t t);
    checks++;
    if (set_ready !== 1'b1) begin
      failures++; $display("FAIL load_ready_pre got=%b exp=1", set_ready);
    end
    set_hh = t.hh; set_mm = t.mm; set_ss = t.ss; set_pm = t.pm;
    set_valid = 1'b1;
    exp_q.push_back(t);
    mdl = t;
    step();
    set_valid = 1'b0;
    checks++;
    if (set_ready !== 1'b0 || set_err !== 1'b0) begin
      failures++; $display("FAIL load_state got ready=%b err=%b exp ready=0 err=0", set_ready, set_err);
    end
    step();
    exp_t = exp_q.pop_front();
    got = now_t();
    checks++;
    if (got !== exp_t) begin
      failures++; $display("FAIL load_time got=%h exp=%h", got, exp_t);
    end
    checks++;
    if (set_ready !== 1'b1) begin
      failures++; $display("FAIL load_ready_post got=%b exp=1", set_ready);
    end
  endtask

  task automatic tick_once();
    mdl = model_inc(mdl);
    exp_q.push_back(mdl);
    enable = 1'b1;
    step();
    enable = 1'b0;
    checks++;
    if (sec_tick !== 1'b1) begin
      failures++; $display("FAIL tick_pulse got=%b exp=1", sec_tick);
      void'(exp_q.pop_front());
    end else begin
      exp_t = exp_q.pop_front();
      got = now_t();
      checks++;
      if (got !== exp_t) begin
        failures++; $display("FAIL tick_time got=%h exp=%h", got, exp_t);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; run = 1'b0; set_valid = 1'b0;
    set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00; set_pm = 1'b0;
    step();
    reset = 1'b0;
    got = now_t();
    checks++;
    if (got !== MIDNIGHT) begin
      failures++; $display("FAIL reset_time got=%h exp=%h", got, MIDNIGHT);
    end
    checks++;
    if (set_ready !== 1'b1 || set_err !== 1'b0 || sec_tick !== 1'b0) begin
      failures++; $display("FAIL reset_flags got ready=%b err=%b tick=%b exp 1 0 0", set_ready, set_err, sec_tick);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      got = now_t();
      checks++;
      if (got !== MIDNIGHT || sec_tick !== 1'b0) begin
        failures++; $display("FAIL stop_hold got=%h tick=%b exp=%h tick=0", got, sec_tick, MIDNIGHT);
      end
    end
    enable = 1'b0;
    mdl = MIDNIGHT;
  endtask

  task automatic test_count();
    int ticks;
    tm_t fin;
    ticks = 0;
    fin = '{hh: 8'h12, mm: 8'h01, ss: 8'h00, pm: 1'b0};
    run = 1'b1;
    step();
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      mdl = model_inc(mdl);
      exp_q.push_back(mdl);
      step();
      if (sec_tick === 1'b1) ticks++;
      exp_t = exp_q.pop_front();
      got = now_t();
      checks++;
      if (got !== exp_t) begin
        failures++; $display("FAIL count_time[%0d] got=%h exp=%h", i, got, exp_t);
      end
    end
    enable = 1'b0;
    checks++;
    if (ticks != 60) begin
      failures++; $display("FAIL count_ticks got=%0d exp=60", ticks);
    end
    got = now_t();
    checks++;
    if (got !== fin) begin
      failures++; $display("FAIL count_final got=%h exp=%h", got, fin);
    end
    step();
    checks++;
    if (sec_tick !== 1'b0) begin
      failures++; $display("FAIL count_idle_tick got=%b exp=0", sec_tick);
    end
  endtask

  task automatic test_wrap();
    tm_t start_t[4];
    tm_t end_t[4];
    start_t[0] = '{hh: 8'h11, mm: 8'h59, ss: 8'h59, pm: 1'b1};
    end_t[0]   = '{hh: 8'h12, mm: 8'h00, ss: 8'h00, pm: 1'b0};
    start_t[1] = '{hh: 8'h12, mm: 8'h59, ss: 8'h59, pm: 1'b0};
    end_t[1]   = '{hh: 8'h01, mm: 8'h00, ss: 8'h00, pm: 1'b0};
    start_t[2] = '{hh: 8'h09, mm: 8'h59, ss: 8'h59, pm: 1'b0};
    end_t[2]   = '{hh: 8'h10, mm: 8'h00, ss: 8'h00, pm: 1'b0};
    start_t[3] = '{hh: 8'h11, mm: 8'h59, ss: 8'h59, pm: 1'b0};
    end_t[3]   = '{hh: 8'h12, mm: 8'h00, ss: 8'h00, pm: 1'b1};
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_load(start_t[i]);
      tick_once();
      got = now_t();
      checks++;
      if (got !== end_t[i]) begin
        failures++; $display("FAIL wrap[%0d] got=%h exp=%h", i, got, end_t[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [7:0] bad_hh[4] = '{8'h13, 8'h01, 8'h00, 8'h05};
    logic [7:0] bad_mm[4] = '{8'h00, 8'h5A, 8'h00, 8'h30};
    logic [7:0] bad_ss[4] = '{8'h00, 8'h00, 8'h00, 8'h60};
    run = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      set_hh = bad_hh[i]; set_mm = bad_mm[i]; set_ss = bad_ss[i]; set_pm = 1'b1;
      set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      got = now_t();
      checks++;
      if (set_err !== 1'b1 || set_ready !== 1'b1 || got !== mdl) begin
        failures++; $display("FAIL invalid[%0d] got err=%b ready=%b t=%h exp err=1 ready=1 t=%h",
                             i, set_err, set_ready, got, mdl);
      end
      step();
      got = now_t();
      checks++;
      if (set_err !== 1'b0 || got !== mdl) begin
        failures++; $display("FAIL invalid_after[%0d] got err=%b t=%h exp err=0 t=%h", i, set_err, got, mdl);
      end
    end
  endtask

  task automatic test_coincident();
    tm_t t;
    t = '{hh: 8'h03, mm: 8'h04, ss: 8'h05, pm: 1'b1};
    run = 1'b1;
    step();
    set_hh = t.hh; set_mm = t.mm; set_ss = t.ss; set_pm = t.pm;
    set_valid = 1'b1; enable = 1'b1;
    exp_q.push_back(t);
    mdl = t;
    step();
    set_valid = 1'b0;
    checks++;
    if (sec_tick !== 1'b0) begin
      failures++; $display("FAIL coinc_hs_tick got=%b exp=0", sec_tick);
    end
    step();
    enable = 1'b0;
    exp_t = exp_q.pop_front();
    got = now_t();
    checks++;
    if (got !== exp_t || sec_tick !== 1'b0) begin
      failures++; $display("FAIL coinc_load got=%h tick=%b exp=%h tick=0", got, sec_tick, exp_t);
    end
    step();
    got = now_t();
    checks++;
    if (got !== t) begin
      failures++; $display("FAIL coinc_hold got=%h exp=%h", got, t);
    end
    tick_once();
  endtask

  task automatic test_run_stop();
    run = 1'b0; enable = 1'b1;
    mdl = model_inc(mdl);
    exp_q.push_back(mdl);
    step();
    exp_t = exp_q.pop_front();
    got = now_t();
    checks++;
    if (sec_tick !== 1'b1 || got !== exp_t) begin
      failures++; $display("FAIL runfall_tick got=%h tick=%b exp=%h tick=1", got, sec_tick, exp_t);
    end
    step();
    got = now_t();
    checks++;
    if (sec_tick !== 1'b0 || got !== mdl) begin
      failures++; $display("FAIL runfall_stop got=%h tick=%b exp=%h tick=0", got, sec_tick, mdl);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    tm_t t1;
    t1 = '{hh: 8'h07, mm: 8'h23, ss: 8'h41, pm: 1'b1};
    run = 1'b1;
    step();
    do_load('{hh: 8'h07, mm: 8'h23, ss: 8'h40, pm: 1'b1});
    tick_once();
    got = now_t();
    checks++;
    if (got !== t1) begin
      failures++; $display("FAIL mid_pre got=%h exp=%h", got, t1);
    end
    enable = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    got = now_t();
    checks++;
    if (got !== MIDNIGHT || set_ready !== 1'b1 || sec_tick !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%h ready=%b tick=%b exp=%h ready=1 tick=0",
                           got, set_ready, sec_tick, MIDNIGHT);
    end
    step();
    got = now_t();
    checks++;
    if (got !== MIDNIGHT || sec_tick !== 1'b0) begin
      failures++; $display("FAIL mid_stop got=%h tick=%b exp=%h tick=0", got, sec_tick, MIDNIGHT);
    end
    step();
    exp_t = '{hh: 8'h12, mm: 8'h00, ss: 8'h01, pm: 1'b0};
    got = now_t();
    checks++;
    if (got !== exp_t || sec_tick !== 1'b1) begin
      failures++; $display("FAIL mid_resume got=%h tick=%b exp=%h tick=1", got, sec_tick, exp_t);
    end
    enable = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_invalid();
    test_coincident();
    test_run_stop();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
